alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester round-robin arbiter that shares a single `alu32` instance between two clients, for example the execute path and an address/branch unit.

- Each client presents operands and an ALU control code with a request.
- The arbiter grants one client and registers its operands into the ALU.
- It captures the ALU result and carry, then returns them to that client with a one-cycle valid pulse.
- It sits between the clients and the `alu32` port set (`iA`, `iB`, `ctrl`, `out`, `oCarry`).

## Interface

Parameters:
- `WIDTH`, default 32, operand/result width (matches `alu32`).
- `CTRL_W`, default 3, ALU control code width.

Ports:
- `iClk`  in  1  clock; one clock domain, all logic on the rising edge.
- `iRst_n`  in  1  reset; synchronous, active-low.
- `iReq0` / `iReq1`  in  1  request from client 0 / client 1.
- `iA0`, `iB0` / `iA1`, `iB1`  in  WIDTH  operands of client 0 / client 1.
- `iCtrl0` / `iCtrl1`  in  CTRL_W  ALU control code of client 0 / client 1.
- `oGnt0` / `oGnt1`  out  1  one-cycle grant pulse; operands have been captured.
- `oValid0` / `oValid1`  out  1  one-cycle result-valid pulse for client 0 / client 1.
- `oOut`  out  WIDTH  registered result, shared by both clients.
- `oCarry`  out  1  registered carry, shared by both clients.
- `oBusy`  out  1  high whenever the state is not IDLE.
- `oAluA`, `oAluB`  out  WIDTH  operands to `alu32` `iA`/`iB`.
- `oAluCtrl`  out  CTRL_W  control code to `alu32` `ctrl`.
- `iAluOut`  in  WIDTH  from `alu32` `out`.
- `iAluCarry`  in  1  from `alu32` `oCarry`.

## Operation

- **State machine:** three states, IDLE → EXEC → RESP → IDLE. Encoding is free.
- **IDLE**
  - If any `iReqN` is high at the edge, select the winner, latch `iAN`/`iBN`/`iCtrlN` into the operand registers, and record the owner.
  - Set the owner's `oGntN` = 1 for the next cycle, then go to EXEC.
  - With no request, stay in IDLE.
- **EXEC**
  - The operand registers drive `oAluA`/`oAluB`/`oAluCtrl`.
  - At the edge, register `iAluOut` → `oOut` and `iAluCarry` → `oCarry`.
  - Set the owner's `oValidN` = 1, then go to RESP.
  - Requests are ignored in EXEC.
- **RESP**
  - `oValidN` is high for exactly this cycle; `oGnt*` = 0.
  - Return to IDLE unconditionally. Requests are ignored.
- **Arbitration:** round-robin priority pointer `prio`, reset value 0.
  - Only one requester high: it wins.
  - Both high: client `prio` wins.
  - After any grant, `prio` = the other client.
- **Request protocol:**
  - A client holds `iReqN` and its operands stable until it observes `oGntN` = 1.
  - It deasserts `iReqN` at the edge ending the grant cycle, or keeps it high to queue another operation.
  - A request still high in IDLE is a new operation.
- **Result hold:**
  - `oOut`/`oCarry` hold their value until the next EXEC capture.
  - Clients sample them only when their `oValidN` is high.
- **Operand registers:** `oAluA`/`oAluB`/`oAluCtrl` hold the last granted operation between operations.
- **Data path:** no arithmetic in this block. Widths pass through unchanged, and results are not interpreted.

## Timing

- Request sampled at edge k:
  - `oGntN` is high in cycle k..k+1, coincident with EXEC.
  - `oValidN`, `oOut` and `oCarry` are valid in cycle k+1..k+2, coincident with RESP.
- The earliest next grant is sampled at edge k+3, giving throughput of one operation per 3 cycles.
- **Reset** (`iRst_n` = 0 at an edge) forces:
  - state IDLE and `prio` = 0;
  - `oGnt*`, `oValid*`, `oBusy` = 0;
  - `oOut` = 0, `oCarry` = 0;
  - `oAluA` = 0, `oAluB` = 0, `oAluCtrl` = 0.
- **Reset mid-operation** (EXEC or RESP): the pending operation is dropped and no `oValid` is produced. The client must re-request.
- **Both requests held continuously:** grants alternate 0, 1, 0, 1; neither client is starved.
- **`iReqN` dropping during EXEC/RESP:** no effect on the operation in flight.

## Test plan

- **Single request:** reset, then client 0 issues A = 1, B = 1, ctrl = 3'b000 → `oGnt0` one cycle after the request edge, `oValid0` the next cycle, `oOut` = 2, `oCarry` = 0, `oValid1` stays 0.
- **Simultaneous requests:** client 0 issues A = 1, B = 0 and client 1 issues A = 5, B = 3, both ctrl = 000, same edge after reset → client 0 served first (`oOut` = 1), then client 1 (`oOut` = 8). The two `oValid` pulses are 3 cycles apart.
- **Fairness:** both requests held for 12 cycles → exactly 4 grants alternating 0, 1, 0, 1; `oBusy` low only on the IDLE cycles.
- **Carry path:** client 1 issues A = 0xFFFFFFFF, B = 1, ctrl = 000 → `oOut` = 0, `oCarry` = 1 with `oValid1`.
- **Reset mid-operation:** assert `iRst_n` = 0 in EXEC → no `oValid` pulse, all outputs 0 on the next cycle, `prio` = 0. The next simultaneous request grants client 0.
- **Idle hold:** no requests for 10 cycles after an operation → `oOut`, `oCarry`, `oAluA`, `oAluB` and `oAluCtrl` unchanged; no grants or valids.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one alu32 between two clients.
// A grant latches the winner's operands into registers that drive the ALU.
// The ALU result and carry are captured on the following edge and handed
// back to the owning client with a one-cycle valid pulse.
//
//   state  | meaning
//   -------+--------------------------------------------------------
//   S_IDLE | waiting for a request; operand registers hold last op
//   S_EXEC | operands on the ALU, grant pulse to owner, capture result
//   S_RESP | result registered, valid pulse to owner
module alu_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 3
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iReq0,
    input  logic              iReq1,
    input  logic [WIDTH-1:0]  iA0,
    input  logic [WIDTH-1:0]  iB0,
    input  logic [WIDTH-1:0]  iA1,
    input  logic [WIDTH-1:0]  iB1,
    input  logic [CTRL_W-1:0] iCtrl0,
    input  logic [CTRL_W-1:0] iCtrl1,
    output logic              oGnt0,
    output logic              oGnt1,
    output logic              oValid0,
    output logic              oValid1,
    output logic [WIDTH-1:0]  oOut,
    output logic              oCarry,
    output logic              oBusy,
    output logic [WIDTH-1:0]  oAluA,
    output logic [WIDTH-1:0]  oAluB,
    output logic [CTRL_W-1:0] oAluCtrl,
    input  logic [WIDTH-1:0]  iAluOut,
    input  logic              iAluCarry
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_prio;
    logic                r_owner;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [CTRL_W-1:0]   r_ctrl;
    logic                w_any_req;
    logic                w_sel1;

    // Client 1 wins when it is the only requester, or both request and it holds priority.
    assign w_any_req = iReq0 | iReq1;
    assign w_sel1    = iReq1 & (~iReq0 | r_prio);

    assign oAluA    = r_a;
    assign oAluB    = r_b;
    assign oAluCtrl = r_ctrl;
    assign oBusy    = (r_state != S_IDLE);

    // Sequencer: arbitration, operand latch, result capture and handshake pulses.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_state <= S_IDLE;
            r_prio  <= 1'b0;
            r_owner <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_ctrl  <= '0;
            oGnt0   <= 1'b0;
            oGnt1   <= 1'b0;
            oValid0 <= 1'b0;
            oValid1 <= 1'b0;
            oOut    <= '0;
            oCarry  <= 1'b0;
        end else begin
            oGnt0   <= 1'b0;
            oGnt1   <= 1'b0;
            oValid0 <= 1'b0;
            oValid1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_sel1;
                        r_prio  <= ~w_sel1;
                        r_a     <= w_sel1 ? iA1    : iA0;
                        r_b     <= w_sel1 ? iB1    : iB0;
                        r_ctrl  <= w_sel1 ? iCtrl1 : iCtrl0;
                        oGnt0   <= ~w_sel1;
                        oGnt1   <= w_sel1;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    oOut    <= iAluOut;
                    oCarry  <= iAluCarry;
                    oValid0 <= ~r_owner;
                    oValid1 <= r_owner;
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios followed by random client traffic.
// The reference model works in absolute edge numbers: an accepted operation
// blocks new grants for three edges, and round-robin priority flips per grant.
module tb_alu_arbiter;

    logic        iClk = 1'b0;
    logic        iRst_n = 1'b0;
    logic        iReq0 = 1'b0, iReq1 = 1'b0;
    logic [31:0] iA0 = '0, iB0 = '0, iA1 = '0, iB1 = '0;
    logic [2:0]  iCtrl0 = '0, iCtrl1 = '0;
    logic        oGnt0, oGnt1, oValid0, oValid1, oCarry, oBusy;
    logic [31:0] oOut, oAluA, oAluB;
    logic [2:0]  oAluCtrl;
    logic [31:0] iAluOut;
    logic        iAluCarry;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    bit hold_req = 1'b0;

    alu_arbiter #(.WIDTH(32), .CTRL_W(3)) dut (
        .iClk(iClk), .iRst_n(iRst_n),
        .iReq0(iReq0), .iReq1(iReq1),
        .iA0(iA0), .iB0(iB0), .iA1(iA1), .iB1(iB1),
        .iCtrl0(iCtrl0), .iCtrl1(iCtrl1),
        .oGnt0(oGnt0), .oGnt1(oGnt1),
        .oValid0(oValid0), .oValid1(oValid1),
        .oOut(oOut), .oCarry(oCarry), .oBusy(oBusy),
        .oAluA(oAluA), .oAluB(oAluB), .oAluCtrl(oAluCtrl),
        .iAluOut(iAluOut), .iAluCarry(iAluCarry)
    );

    always #5 iClk = ~iClk;

    // Stand-in for alu32: {carry, result}.
    function automatic logic [32:0] alu_fn(logic [31:0] a, logic [31:0] b, logic [2:0] c);
        case (c)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {1'b0, ~a};
            3'd6:    return {a, 1'b0};
            default: return {32'd0, a < b};
        endcase
    endfunction

    always_comb {iAluCarry, iAluOut} = alu_fn(oAluA, oAluB, oAluCtrl);

    // Reference model state.
    int          n = 0;
    int          g_edge = -100;
    int          next_free = 0;
    bit          g_owner = 1'b0;
    bit          m_prio = 1'b0;
    logic [31:0] e_a = '0, e_b = '0, e_out = '0, p_out = '0;
    logic [2:0]  e_ctrl = '0;
    logic        e_carry = 1'b0, p_carry = 1'b0;

    // Model update on each rising edge from the inputs presented at that edge.
    always @(posedge iClk) begin
        n = n + 1;
        if (!iRst_n) begin
            g_edge = -100; next_free = n + 1; m_prio = 1'b0;
            e_a = '0; e_b = '0; e_ctrl = '0; e_out = '0; e_carry = 1'b0;
        end else begin
            if (n - g_edge == 1) begin
                e_out = p_out; e_carry = p_carry;
            end
            if (n >= next_free && (iReq0 || iReq1)) begin
                g_owner = (iReq0 && iReq1) ? m_prio : iReq1;
                g_edge = n;
                next_free = n + 3;
                m_prio = !g_owner;
                e_a    = g_owner ? iA1 : iA0;
                e_b    = g_owner ? iB1 : iB0;
                e_ctrl = g_owner ? iCtrl1 : iCtrl0;
                {p_carry, p_out} = alu_fn(e_a, e_b, e_ctrl);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %h want %h", tag, n, obs, exp);
        end
    endtask

    // Compare every output mid-cycle against the model.
    always @(negedge iClk) begin
        if (chk_en) begin
            chk("gnt0",   32'(oGnt0),   32'(g_edge == n && !g_owner));
            chk("gnt1",   32'(oGnt1),   32'(g_edge == n && g_owner));
            chk("valid0", 32'(oValid0), 32'(g_edge == n - 1 && !g_owner));
            chk("valid1", 32'(oValid1), 32'(g_edge == n - 1 && g_owner));
            chk("busy",   32'(oBusy),   32'(n - g_edge <= 1 && n >= g_edge));
            chk("out",    oOut,         e_out);
            chk("carry",  32'(oCarry),  32'(e_carry));
            chk("alu_a",  oAluA,        e_a);
            chk("alu_b",  oAluB,        e_b);
            chk("alu_ctrl", 32'(oAluCtrl), 32'(e_ctrl));
        end
    end

    task automatic set0(input logic r, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        iReq0 = r; iA0 = a; iB0 = b; iCtrl0 = c;
    endtask

    task automatic set1(input logic r, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        iReq1 = r; iA1 = a; iB1 = b; iCtrl1 = c;
    endtask

    // Advance k cycles; a client drops its request once it sees its grant.
    task automatic cycles(input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge iClk);
            if (!hold_req) begin
                if (oGnt0) iReq0 = 1'b0;
                if (oGnt1) iReq1 = 1'b0;
            end
        end
    endtask

    initial begin
        iRst_n = 1'b0;
        repeat (2) @(negedge iClk);
        iRst_n = 1'b1;
        chk_en = 1'b1;
        cycles(2);

        // single request, add 1+1
        set0(1'b1, 32'd1, 32'd1, 3'b000);
        cycles(5);

        // simultaneous requests, client 0 first
        set0(1'b1, 32'd1, 32'd0, 3'b000);
        set1(1'b1, 32'd5, 32'd3, 3'b000);
        cycles(8);

        // fairness with both held
        hold_req = 1'b1;
        set0(1'b1, 32'h10, 32'h20, 3'b000);
        set1(1'b1, 32'h30, 32'h40, 3'b100);
        cycles(12);
        hold_req = 1'b0;
        iReq0 = 1'b0; iReq1 = 1'b0;
        cycles(4);

        // carry out of the top bit
        set1(1'b1, 32'hFFFF_FFFF, 32'd1, 3'b000);
        cycles(5);

        // reset while in EXEC drops the operation
        set1(1'b1, 32'd7, 32'd9, 3'b000);
        cycles(1);
        iReq1 = 1'b0;
        iRst_n = 1'b0;
        cycles(1);
        iRst_n = 1'b1;
        set0(1'b1, 32'd2, 32'd3, 3'b011);
        set1(1'b1, 32'd4, 32'd6, 3'b001);
        cycles(8);

        // idle hold
        cycles(10);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge iClk);
            if (iReq0 && oGnt0) begin
                if ($urandom_range(1, 0) == 0) iReq0 = 1'b0;
                else set0(1'b1, $urandom, $urandom, 3'($urandom_range(7, 0)));
            end else if (!iReq0 && $urandom_range(9, 0) < 4) begin
                set0(1'b1, $urandom, $urandom, 3'($urandom_range(7, 0)));
            end
            if (iReq1 && oGnt1) begin
                if ($urandom_range(1, 0) == 0) iReq1 = 1'b0;
                else set1(1'b1, $urandom, $urandom, 3'($urandom_range(7, 0)));
            end else if (!iReq1 && $urandom_range(9, 0) < 4) begin
                set1(1'b1, $urandom, $urandom, 3'($urandom_range(7, 0)));
            end
            if ($urandom_range(299, 0) == 0) iRst_n = 1'b0;
            else iRst_n = 1'b1;
        end
        iRst_n = 1'b1;
        iReq0 = 1'b0; iReq1 = 1'b0;
        cycles(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
